z16_dma_engine: RTL and testbench

Bus initiator for the Z16 data memory port (addr / wen / wdata / rdata). It performs block copy (memory-to-memory) and block fill (constant-to-memory) on a start pulse, generating every address, write-enable and write-data cycle itself. It sits beside the CPU datapath and shares the data memory through an external mux controlled by o_busy. It is the active requester; the data memory is its passive responder.

---
 rtl/z16_pkg.sv | 34 +++
 rtl/z16_dma_rdwait.sv | 29 ++
 rtl/z16_dma_engine.sv | 118 +++++++++++
 tb/tb_z16_dma_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/z16_pkg.sv
// Shared Z16 types for the DMA engine: word width, FSM encoding, mode values
// and the latched transfer context.
package z16_pkg;

  localparam int Z16_W = 16;
  localparam int RDW_W = 2;   // wide enough for RD_LAT 0..2

  typedef logic [Z16_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef struct packed {
    logic  mode;
    word_t src;
    word_t dst;
    word_t cnt;
    word_t fill;
  } dma_ctx_t;

  // 16-bit address step, wraps mod 2^16
  function automatic word_t addr_inc(input word_t a, input word_t step);
    return a + step;
  endfunction

endpackage

// File: rtl/z16_dma_rdwait.sv
// Read-latency down-counter: raises o_cap in the cycle whose read data is valid,
// counting RD_LAT cycles from the READ cycle.
module z16_dma_rdwait
  import z16_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_arm,
  input  logic i_run,
  output logic o_cap
);

  logic [RDW_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      cnt <= '0;
    else if (i_arm)
      cnt <= RDW_W'(RD_LAT);
    else if (i_run && cnt != '0)
      cnt <= cnt - RDW_W'(1);
  end

  // With zero latency the READ cycle itself carries the data
  assign o_cap = i_arm ? (RD_LAT == 0) : (i_run && cnt == RDW_W'(1));

endmodule

// File: rtl/z16_dma_engine.sv
// Z16 data-memory DMA initiator: block copy and block fill driven by a start
// pulse. All outputs are registered alongside the state.
module z16_dma_engine
  import z16_pkg::*;
#(
  parameter int          RD_LAT    = 0,
  parameter logic [15:0] ADDR_STEP = 16'd1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [15:0] i_src,
  input  logic [15:0] i_dst,
  input  logic [15:0] i_len,
  input  logic [15:0] i_fill,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_aborted,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [15:0] o_mem_data,
  input  logic [15:0] i_mem_data
);

  state_t   state;
  dma_ctx_t ctx;
  logic     rd_cap;
  word_t    src_nxt, dst_nxt;

  assign src_nxt = addr_inc(ctx.src, ADDR_STEP);
  assign dst_nxt = addr_inc(ctx.dst, ADDR_STEP);

  z16_dma_rdwait #(.RD_LAT(RD_LAT)) u_rdwait (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_arm (state == ST_READ),
    .i_run (state == ST_WAIT),
    .o_cap (rd_cap)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      ctx        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wen  <= 1'b0;
      o_mem_data <= '0;
    end else begin
      o_done    <= 1'b0;
      o_mem_wen <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            ctx       <= '{mode: i_mode, src: i_src, dst: i_dst, cnt: i_len, fill: i_fill};
            o_aborted <= 1'b0;
            o_busy    <= 1'b1;
            if (i_len == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else if (i_mode == MODE_FILL) begin
              state      <= ST_WRITE;
              o_mem_addr <= i_dst;
              o_mem_wen  <= 1'b1;
              o_mem_data <= i_fill;
            end else begin
              state      <= ST_READ;
              o_mem_addr <= i_src;
            end
          end
        end
        // Abort here drops the outstanding read; no write is issued
        ST_READ, ST_WAIT: begin
          if (i_abort) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_aborted <= 1'b1;
          end else if (rd_cap) begin
            state      <= ST_WRITE;
            o_mem_addr <= ctx.dst;
            o_mem_wen  <= 1'b1;
            o_mem_data <= i_mem_data;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WRITE: begin
          ctx.dst <= dst_nxt;
          if (ctx.mode == MODE_COPY)
            ctx.src <= src_nxt;
          ctx.cnt <= ctx.cnt - 16'd1;
          if (i_abort || ctx.cnt == 16'd1) begin
            state     <= ST_DONE;
            o_done    <= 1'b1;
            o_aborted <= i_abort;
          end else if (ctx.mode == MODE_FILL) begin
            o_mem_addr <= dst_nxt;
            o_mem_wen  <= 1'b1;
            o_mem_data <= ctx.fill;
          end else begin
            state      <= ST_READ;
            o_mem_addr <= src_nxt;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z16_dma_engine.sv
// Directed bench for z16_dma_engine: one instance at RD_LAT=0, one at RD_LAT=2,
// each with its own memory model.
module tb_z16_dma_engine;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        start0, start2, mode, abort;
  logic [15:0] src, dst, len, fill;

  logic        busy0, done0, ab0, wen0;
  logic [15:0] addr0, wdata0, rdata0;
  logic        busy2, done2, ab2, wen2;
  logic [15:0] addr2, wdata2, rdata2;

  logic [15:0] mem0 [0:65535];
  logic [15:0] mem2 [0:65535];
  logic [15:0] a1, a2;
  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  z16_dma_engine #(.RD_LAT(0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(start0), .i_mode(mode),
    .i_src(src), .i_dst(dst), .i_len(len), .i_fill(fill), .i_abort(abort),
    .o_busy(busy0), .o_done(done0), .o_aborted(ab0),
    .o_mem_addr(addr0), .o_mem_wen(wen0), .o_mem_data(wdata0), .i_mem_data(rdata0)
  );

  z16_dma_engine #(.RD_LAT(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(start2), .i_mode(mode),
    .i_src(src), .i_dst(dst), .i_len(len), .i_fill(fill), .i_abort(abort),
    .o_busy(busy2), .o_done(done2), .o_aborted(ab2),
    .o_mem_addr(addr2), .o_mem_wen(wen2), .o_mem_data(wdata2), .i_mem_data(rdata2)
  );

  always_ff @(posedge i_clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem2[pl_addr] <= pl_data;
    end
    if (wen0) mem0[addr0] <= wdata0;
    if (wen2) mem2[addr2] <= wdata2;
    a1 <= addr2;
    a2 <= a1;
  end

  assign rdata0 = mem0[addr0];
  assign rdata2 = mem2[a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge i_clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge i_clk);
    pl_en = 1'b0;
  endtask

  // Returns at the sample point of the o_done cycle; lat counts cycles after start.
  task automatic run(input bit sel, input logic md, input logic [15:0] s, input logic [15:0] d,
                     input logic [15:0] n, input logic [15:0] f, input int abort_at,
                     output int lat, output logic [31:0] pat, output int nwen, output logic abt);
    @(negedge i_clk);
    mode = md; src = s; dst = d; len = n; fill = f;
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    @(negedge i_clk);
    start0 = 1'b0; start2 = 1'b0;
    lat = 0; pat = '0; nwen = 0; abt = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      logic w, dn;
      w  = sel ? wen2 : wen0;
      dn = sel ? done2 : done0;
      abort = (c == abort_at);
      if (w) nwen++;
      pat = {pat[30:0], w};
      if (dn) begin
        lat = c;
        abt = sel ? ab2 : ab0;
        break;
      end
      @(negedge i_clk);
    end
    abort = 1'b0;
  endtask

  int          lat, nwen;
  logic [31:0] pat;
  logic        abt, any_done;

  initial begin
    i_rst = 1'b1; start0 = 1'b0; start2 = 1'b0; mode = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; fill = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_abt",  {31'd0, ab0},   32'd0);
    chk("rst_wen",  {31'd0, wen0},  32'd0);
    chk("rst_addr", {16'd0, addr0}, 32'd0);
    chk("rst_data", {16'd0, wdata2}, 32'd0);
    i_rst = 1'b0;

    // fill 4 words
    preload(16'h0104, 16'hCAFE);
    run(0, 1'b1, 16'h0, 16'h0100, 16'd4, 16'h5555, 0, lat, pat, nwen, abt);
    chk("fill_lat", lat, 32'd5);
    chk("fill_pat", pat, 32'h1E);
    for (int i = 0; i < 4; i++) chk("fill_mem", {16'd0, mem0[16'h0100 + 16'(i)]}, 32'h5555);
    chk("fill_tail", {16'd0, mem0[16'h0104]}, 32'hCAFE);

    // copy at both read latencies
    preload(16'h0100, 16'h1111);
    preload(16'h0101, 16'h2222);
    preload(16'h0102, 16'h3333);
    run(0, 1'b0, 16'h0100, 16'h0200, 16'd3, 16'h0, 0, lat, pat, nwen, abt);
    chk("cp0_lat", lat, 32'd7);
    chk("cp0_pat", pat, 32'h2A);
    chk("cp0_m0", {16'd0, mem0[16'h0200]}, 32'h1111);
    chk("cp0_m1", {16'd0, mem0[16'h0201]}, 32'h2222);
    chk("cp0_m2", {16'd0, mem0[16'h0202]}, 32'h3333);
    run(1, 1'b0, 16'h0100, 16'h0200, 16'd3, 16'h0, 0, lat, pat, nwen, abt);
    chk("cp2_lat", lat, 32'd13);
    chk("cp2_pat", pat, 32'h222);
    chk("cp2_m0", {16'd0, mem2[16'h0200]}, 32'h1111);
    chk("cp2_m1", {16'd0, mem2[16'h0201]}, 32'h2222);
    chk("cp2_m2", {16'd0, mem2[16'h0202]}, 32'h3333);

    // zero length
    run(0, 1'b1, 16'h0, 16'h0600, 16'd0, 16'h9999, 0, lat, pat, nwen, abt);
    chk("len0_lat", lat, 32'd1);
    chk("len0_nwen", nwen, 32'd0);
    chk("len0_busy", {31'd0, busy0}, 32'd1);
    @(negedge i_clk);
    chk("len0_idle", {31'd0, busy0}, 32'd0);

    // abort during third fill write
    preload(16'h0303, 16'hDEAD);
    run(0, 1'b1, 16'h0, 16'h0300, 16'd8, 16'hA5A5, 3, lat, pat, nwen, abt);
    chk("abt_lat", lat, 32'd4);
    chk("abt_nwen", nwen, 32'd3);
    chk("abt_flag", {31'd0, abt}, 32'd1);
    chk("abt_m2", {16'd0, mem0[16'h0302]}, 32'hA5A5);
    chk("abt_m3", {16'd0, mem0[16'h0303]}, 32'hDEAD);
    repeat (3) @(negedge i_clk);
    chk("abt_hold", {31'd0, ab0}, 32'd1);

    // abort while a copy read is pending
    run(0, 1'b0, 16'h0100, 16'h0700, 16'd2, 16'h0, 1, lat, pat, nwen, abt);
    chk("abtr_lat", lat, 32'd2);
    chk("abtr_nwen", nwen, 32'd0);
    chk("abtr_flag", {31'd0, abt}, 32'd1);

    // address wrap
    run(0, 1'b1, 16'h0, 16'hFFFE, 16'd4, 16'h7777, 0, lat, pat, nwen, abt);
    chk("wrap_pat", pat, 32'h1E);
    chk("wrap_abt", {31'd0, abt}, 32'd0);
    chk("wrap_fffe", {16'd0, mem0[16'hFFFE]}, 32'h7777);
    chk("wrap_ffff", {16'd0, mem0[16'hFFFF]}, 32'h7777);
    chk("wrap_0000", {16'd0, mem0[16'h0000]}, 32'h7777);
    chk("wrap_0001", {16'd0, mem0[16'h0001]}, 32'h7777);

    // reset mid-transfer after two writes
    preload(16'h0402, 16'hBEEF);
    @(negedge i_clk);
    mode = 1'b1; dst = 16'h0400; len = 16'd6; fill = 16'h1234; start0 = 1'b1;
    @(negedge i_clk);
    start0 = 1'b0;
    chk("mrst_a1", {15'd0, wen0, addr0}, 32'h1_0400);
    @(negedge i_clk);
    chk("mrst_a2", {15'd0, wen0, addr0}, 32'h1_0401);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("mrst_out", {busy0, done0, ab0, wen0, addr0, wdata0[11:0]}, 32'd0);
    any_done = 1'b0;
    repeat (4) begin
      any_done |= done0 | wen0;
      @(negedge i_clk);
    end
    chk("mrst_quiet", {31'd0, any_done}, 32'd0);
    chk("mrst_m1", {16'd0, mem0[16'h0401]}, 32'h1234);
    chk("mrst_m2", {16'd0, mem0[16'h0402]}, 32'hBEEF);
    run(0, 1'b1, 16'h0, 16'h0500, 16'd1, 16'h4321, 0, lat, pat, nwen, abt);
    chk("post_lat", lat, 32'd2);
    chk("post_mem", {16'd0, mem0[16'h0500]}, 32'h4321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
